// File: rtl/console_textbuf_pkg.sv
// Shared types and constants for the console text buffer.
package console_textbuf_pkg;

  typedef enum logic [1:0] {
    ST_INIT_CLEAR,
    ST_IDLE,
    ST_LINE_CLEAR,
    ST_FULL_CLEAR
  } state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  localparam logic [7:0] BLANK_CHAR  = 8'h20;
  localparam logic [7:0] CURSOR_CHAR = 8'h5F;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] code;
  } cell_t;

  // (base + off) mod modulus for operands already below modulus
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                           input int unsigned modulus);
    int unsigned s;
    s = base + off;
    return (s >= modulus) ? s - modulus : s;
  endfunction

endpackage

// File: rtl/console_textbuf_ram.sv
// Simple dual-port screen RAM: one write port, registered read port, old data on collision.
module console_textbuf_ram #(
  parameter int unsigned DEPTH = 2400,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/console_textbuf.sv
// Character-cell text buffer with cursor, wrap, hardware scroll and a 2-cycle display read port.
// Optional cursor overlay on the display port: define CONSOLE_TEXTBUF_CURSOR_EN.
module console_textbuf
  import console_textbuf_pkg::*;
#(
  parameter int unsigned BIT_WIDTH    = 12,
  parameter int unsigned BIT_HEIGHT   = 11,
  parameter int unsigned FONT_WIDTH   = 8,
  parameter int unsigned FONT_HEIGHT  = 16,
  parameter int unsigned COLUMNS      = 80,
  parameter int unsigned ROWS         = 30,
  parameter logic [7:0]  DEFAULT_ATTR = 8'h07
) (
  input  logic                        clk_pixel,
  input  logic                        reset,
  input  logic                        char_valid,
  input  logic [7:0]                  char_data,
  input  logic [7:0]                  char_attr,
  output logic                        char_ready,
  input  logic [BIT_WIDTH-1:0]        cx,
  input  logic [BIT_HEIGHT-1:0]       cy,
  output logic [7:0]                  codepoint,
  output logic [7:0]                  attribute,
  output logic [$clog2(COLUMNS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]     cursor_row
);

  localparam int unsigned CELLS = COLUMNS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned CW    = $clog2(COLUMNS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned FW_SH = $clog2(FONT_WIDTH);
  localparam int unsigned FH_SH = $clog2(FONT_HEIGHT);

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [RW-1:0]   top_row;

  logic            accept;
  logic            is_print;
  logic            wrap_now;
  logic            do_adv;
  logic [AW-1:0]   cur_addr;

  logic            we;
  logic [AW-1:0]   waddr;
  cell_t           wdata;

  logic [BIT_WIDTH-1:0]  cell_col;
  logic [BIT_HEIGHT-1:0] cell_row;
  logic                  in_area;
  logic [AW-1:0]         rd_addr_c;
  logic [AW-1:0]         rd_addr;
  logic                  area1;
  logic                  area2;
  logic [15:0]           rdata_raw;
  cell_t                 rdata;

  assign accept   = char_valid && char_ready;
  assign is_print = !(char_data inside {CR, LF, BS, FF});
  assign wrap_now = is_print && (cursor_col == CW'(COLUMNS - 1));
  assign do_adv   = (char_data == LF) || wrap_now;
  assign cur_addr = AW'(wrap_add(32'(top_row), 32'(cursor_row), ROWS) * COLUMNS
                        + 32'(cursor_col));

  // Write port arbitration: clears own the port outside IDLE
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = cell_t'{attr: DEFAULT_ATTR, code: BLANK_CHAR};
    case (state)
      ST_INIT_CLEAR, ST_FULL_CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
      end
      ST_LINE_CLEAR: begin
        we    = 1'b1;
        waddr = AW'(wrap_add(32'(top_row), ROWS - 1, ROWS) * COLUMNS + 32'(clr_cnt));
      end
      default: begin
        if (accept && is_print) begin
          we    = 1'b1;
          waddr = cur_addr;
          wdata = cell_t'{attr: char_attr, code: char_data};
        end
      end
    endcase
  end

  // Control FSM: cursor, scroll origin and clear sequencing
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT_CLEAR;
      char_ready <= 1'b0;
      clr_cnt    <= '0;
      top_row    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      case (state)
        ST_INIT_CLEAR, ST_FULL_CLEAR: begin
          if (clr_cnt == AW'(CELLS - 1)) begin
            state      <= ST_IDLE;
            char_ready <= 1'b1;
            clr_cnt    <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_LINE_CLEAR: begin
          if (clr_cnt == AW'(COLUMNS - 1)) begin
            state      <= ST_IDLE;
            char_ready <= 1'b1;
            clr_cnt    <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            if (char_data == FF) begin
              cursor_col <= '0;
              cursor_row <= '0;
              top_row    <= '0;
              clr_cnt    <= '0;
              char_ready <= 1'b0;
              state      <= ST_FULL_CLEAR;
            end else begin
              if (char_data == CR || char_data == LF || wrap_now) begin
                cursor_col <= '0;
              end else if (char_data == BS) begin
                if (cursor_col != '0) cursor_col <= cursor_col - 1'b1;
              end else begin
                cursor_col <= cursor_col + 1'b1;
              end
              // Bottom row advance scrolls the origin and blanks the recycled row
              if (do_adv) begin
                if (cursor_row < RW'(ROWS - 1)) begin
                  cursor_row <= cursor_row + 1'b1;
                end else begin
                  top_row    <= (top_row == RW'(ROWS - 1)) ? '0 : top_row + 1'b1;
                  clr_cnt    <= '0;
                  char_ready <= 1'b0;
                  state      <= ST_LINE_CLEAR;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign cell_col  = cx >> FW_SH;
  assign cell_row  = cy >> FH_SH;
  assign in_area   = (cell_col < BIT_WIDTH'(COLUMNS)) && (cell_row < BIT_HEIGHT'(ROWS));
  assign rd_addr_c = in_area ? AW'(wrap_add(32'(top_row), 32'(cell_row[RW-1:0]), ROWS) * COLUMNS
                                   + 32'(cell_col[CW-1:0])) : '0;

`ifdef CONSOLE_TEXTBUF_CURSOR_EN
  logic hit_c;
  logic hit1;
  logic hit2;

  assign hit_c = in_area && (state == ST_IDLE) && (cell_col[CW-1:0] == cursor_col)
                 && (cell_row[RW-1:0] == cursor_row);

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      hit1 <= 1'b0;
      hit2 <= 1'b0;
    end else begin
      hit1 <= hit_c;
      hit2 <= hit1;
    end
  end
`endif

  // Display pipeline: stage 1 address, stage 2 RAM read
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      area1   <= 1'b0;
      area2   <= 1'b0;
    end else begin
      rd_addr <= rd_addr_c;
      area1   <= in_area;
      area2   <= area1;
    end
  end

  console_textbuf_ram #(
    .DEPTH (CELLS),
    .AW    (AW),
    .DW    (16)
  ) u_ram (
    .clk   (clk_pixel),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rdata_raw)
  );

  assign rdata = cell_t'(rdata_raw);

  always_comb begin
    codepoint = BLANK_CHAR;
    attribute = 8'h00;
    if (area2) begin
      codepoint = rdata.code;
      attribute = rdata.attr;
`ifdef CONSOLE_TEXTBUF_CURSOR_EN
      if (hit2) begin
        codepoint = CURSOR_CHAR;
        attribute = {1'b1, rdata.attr[6:0]};
      end
`endif
    end
  end

endmodule

// File: tb/tb_console_textbuf.sv
// Self-checking bench for console_textbuf against a logical-screen reference model.
module tb_console_textbuf;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic        char_valid;
  logic [7:0]  char_data;
  logic [7:0]  char_attr;
  logic        char_ready;
  logic [11:0] cx;
  logic [10:0] cy;
  logic [7:0]  codepoint;
  logic [7:0]  attribute;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int checks = 0;
  int failures = 0;

  // Reference model: the screen as the viewer sees it, row 0 on top
  logic [7:0] scr_c [ROWS][COLS];
  logic [7:0] scr_a [ROWS][COLS];
  int mcol = 0;
  int mrow = 0;

  console_textbuf #(
    .BIT_WIDTH(12), .BIT_HEIGHT(11), .FONT_WIDTH(8), .FONT_HEIGHT(16),
    .COLUMNS(80), .ROWS(30), .DEFAULT_ATTR(8'h07)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_attr  (char_attr),
    .char_ready (char_ready),
    .cx         (cx),
    .cy         (cy),
    .codepoint  (codepoint),
    .attribute  (attribute),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic void m_blank_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        scr_c[r][c] = 8'h20;
        scr_a[r][c] = 8'h07;
      end
  endfunction

  function automatic int m_advance();
    if (mrow < ROWS - 1) begin
      mrow++;
      return 0;
    end
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) begin
        scr_c[r][c] = scr_c[r+1][c];
        scr_a[r][c] = scr_a[r+1][c];
      end
    for (int c = 0; c < COLS; c++) begin
      scr_c[ROWS-1][c] = 8'h20;
      scr_a[ROWS-1][c] = 8'h07;
    end
    return COLS;
  endfunction

  // Applies one accepted byte; returns the number of cycles ready must stay low
  function automatic int m_byte(input logic [7:0] d, input logic [7:0] a);
    int stall = 0;
    case (d)
      8'h0D: mcol = 0;
      8'h0A: begin mcol = 0; stall = m_advance(); end
      8'h08: if (mcol > 0) mcol--;
      8'h0C: begin mcol = 0; mrow = 0; m_blank_all(); stall = COLS * ROWS; end
      default: begin
        scr_c[mrow][mcol] = d;
        scr_a[mrow][mcol] = a;
        mcol++;
        if (mcol == COLS) begin
          mcol = 0;
          stall = m_advance();
        end
      end
    endcase
    return stall;
  endfunction

  function automatic void exp_cell(input int col, input int row,
                                   output logic [7:0] c, output logic [7:0] a);
    if (col >= COLS || row >= ROWS) begin
      c = 8'h20;
      a = 8'h00;
    end else begin
      c = scr_c[row][col];
      a = scr_a[row][col];
`ifdef CONSOLE_TEXTBUF_CURSOR_EN
      if (col == mcol && row == mrow) begin
        c = 8'h5F;
        a = {1'b1, a[6:0]};
      end
`endif
    end
  endfunction

  task automatic read_cell(input int col, input int row, output logic [7:0] c, output logic [7:0] a);
    cx = 12'(col * 8 + int'($urandom_range(0, 7)));
    cy = 11'(row * 16 + int'($urandom_range(0, 15)));
    repeat (2) @(posedge clk_pixel);
    #1;
    c = codepoint;
    a = attribute;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (char_ready !== 1'b1 && n < 3000) begin
      @(posedge clk_pixel);
      #1;
      n++;
    end
  endtask

  // Sends one byte, then reports how many cycles ready stayed low and the model's expectation
  task automatic send_byte(input logic [7:0] d, input logic [7:0] a, output int low, output int stall);
    int n;
    wait_ready(n);
    char_valid = 1'b1;
    char_data  = d;
    char_attr  = a;
    @(posedge clk_pixel);
    #1;
    char_valid = 1'b0;
    char_data  = 8'($urandom);
    char_attr  = 8'($urandom);
    stall = m_byte(d, a);
    wait_ready(low);
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] oc, oa, ec, ea;
    reset = 1'b1; char_valid = 1'b0; char_data = 8'h00; char_attr = 8'h00;
    cx = '0; cy = '0;
    repeat (3) @(posedge clk_pixel);
    #1;
    checks++;
    if (char_ready !== 1'b0 || codepoint !== 8'h20 || attribute !== 8'h00 ||
        cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      failures++;
      $display("FAIL reset_values got ready=%b cp=%h at=%h cur=(%0d,%0d) required 0/20/00/(0,0)",
               char_ready, codepoint, attribute, cursor_col, cursor_row);
    end
    reset = 1'b0;
    m_blank_all(); mcol = 0; mrow = 0;
    wait_ready(n);
    checks++;
    if (n != COLS * ROWS) begin
      failures++;
      $display("FAIL init_clear_len got=%0d required=%0d", n, COLS * ROWS);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(c, r, oc, oa);
        exp_cell(c, r, ec, ea);
        checks++;
        if (oc !== ec || oa !== ea) begin
          failures++;
          $display("FAIL init_cell(%0d,%0d) got=%h/%h required=%h/%h", c, r, oc, oa, ec, ea);
        end
      end
    for (int i = 0; i < 8; i++) begin
      int c = (i % 2 == 0) ? int'($urandom_range(80, 511)) : int'($urandom_range(0, 79));
      int r = (i % 2 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(30, 127));
      read_cell(c, r, oc, oa);
      checks++;
      if (oc !== 8'h20 || oa !== 8'h00) begin
        failures++;
        $display("FAIL outside(%0d,%0d) got=%h/%h required=20/00", c, r, oc, oa);
      end
    end
  endtask

  task automatic test_ab();
    int low, stall;
    logic [7:0] ec, ea;
    send_byte(8'h41, 8'h1E, low, stall);
    send_byte(8'h42, 8'h1E, low, stall);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        cx = 12'(i);
        cy = 11'd0;
      end
      if (i >= 2) begin
        exp_cell((i - 2) / 8, 0, ec, ea);
        checks++;
        if (codepoint !== ec || attribute !== ea || (i - 2 < 8 && ec !== 8'h41)) begin
          failures++;
          $display("FAIL ab_sweep cx=%0d got=%h/%h required=%h/%h", i - 2, codepoint, attribute, ec, ea);
        end
      end
      @(posedge clk_pixel);
      #1;
    end
    checks++;
    if (cursor_col !== 7'd2 || cursor_row !== 5'd0) begin
      failures++;
      $display("FAIL ab_cursor got=(%0d,%0d) required=(2,0)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_row_fill();
    int low, stall;
    logic [7:0] oc, oa, ec, ea;
    send_byte(8'h0D, 8'h00, low, stall);
    for (int i = 0; i < COLS; i++) send_byte(8'h58, 8'h2C, low, stall);
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd1) begin
      failures++;
      $display("FAIL fill_cursor got=(%0d,%0d) required=(0,1)", cursor_col, cursor_row);
    end
    for (int i = 0; i < 4; i++) begin
      int c = (i == 0) ? 0 : (i == 1) ? COLS - 1 : int'($urandom_range(0, COLS - 1));
      int r = (i < 3) ? 0 : 1;
      read_cell(c, r, oc, oa);
      exp_cell(c, r, ec, ea);
      checks++;
      if (oc !== ec || oa !== ea) begin
        failures++;
        $display("FAIL fill_cell(%0d,%0d) got=%h/%h required=%h/%h", c, r, oc, oa, ec, ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    int low, stall;
    logic [7:0] oc, oa, ec, ea;
    send_byte(8'h0D, 8'h00, low, stall);
    char_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      char_data = 8'($urandom_range(8'h30, 8'h7A));
      char_attr = 8'($urandom);
      @(posedge clk_pixel);
      #1;
      void'(m_byte(char_data, char_attr));
      checks++;
      if (char_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready i=%0d got=%b required=1", i, char_ready);
      end
    end
    char_valid = 1'b0;
    for (int c = 0; c < 21; c++) begin
      read_cell(c, mrow, oc, oa);
      exp_cell(c, mrow, ec, ea);
      checks++;
      if (oc !== ec || oa !== ea) begin
        failures++;
        $display("FAIL b2b_cell(%0d,%0d) got=%h/%h required=%h/%h", c, mrow, oc, oa, ec, ea);
      end
    end
  endtask

  task automatic test_random_stream();
    int low, stall, sel;
    logic [7:0] d, oc, oa, ec, ea;
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 15));
      case (sel)
        0: d = 8'h0D;
        1: d = 8'h0A;
        2: d = 8'h08;
        default: begin
          d = 8'($urandom_range(0, 255));
          if (d inside {8'h0D, 8'h0A, 8'h08, 8'h0C}) d = 8'h2A;
        end
      endcase
      send_byte(d, 8'($urandom), low, stall);
      checks++;
      if (low != stall) begin
        failures++;
        $display("FAIL rand_ready_low byte=%h got=%0d required=%0d", d, low, stall);
      end
    end
    checks++;
    if (cursor_col !== 7'(mcol) || cursor_row !== 5'(mrow)) begin
      failures++;
      $display("FAIL rand_cursor got=(%0d,%0d) required=(%0d,%0d)", cursor_col, cursor_row, mcol, mrow);
    end
    for (int i = 0; i < 60; i++) begin
      int c = (i == 0) ? mcol : int'($urandom_range(0, COLS - 1));
      int r = (i == 0) ? mrow : int'($urandom_range(0, ROWS - 1));
      read_cell(c, r, oc, oa);
      exp_cell(c, r, ec, ea);
      checks++;
      if (oc !== ec || oa !== ea) begin
        failures++;
        $display("FAIL rand_cell(%0d,%0d) got=%h/%h required=%h/%h", c, r, oc, oa, ec, ea);
      end
    end
  endtask

  task automatic test_scroll();
    int low, stall;
    logic [7:0] oc, oa, ec, ea;
    while (mrow < ROWS - 1) send_byte(8'h0A, 8'h00, low, stall);
    send_byte(8'h0D, 8'h00, low, stall);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(8'h41, 8'h5A)), 8'($urandom), low, stall);
    send_byte(8'h0A, 8'h00, low, stall);
    checks++;
    if (low != COLS || stall != COLS) begin
      failures++;
      $display("FAIL lf_scroll_low got=%0d required=%0d", low, COLS);
    end
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd29) begin
      failures++;
      $display("FAIL scroll_cursor got=(%0d,%0d) required=(0,29)", cursor_col, cursor_row);
    end
    for (int k = 0; k < 3; k++) begin
      int r = (k == 0) ? 0 : (k == 1) ? 28 : 29;
      for (int c = 0; c < COLS; c++) begin
        read_cell(c, r, oc, oa);
        exp_cell(c, r, ec, ea);
        checks++;
        if (oc !== ec || oa !== ea) begin
          failures++;
          $display("FAIL scroll_cell(%0d,%0d) got=%h/%h required=%h/%h", c, r, oc, oa, ec, ea);
        end
      end
    end
    for (int i = 0; i < COLS - 1; i++) send_byte(8'h57, 8'h3A, low, stall);
    send_byte(8'h5A, 8'h4B, low, stall);
    checks++;
    if (low != COLS || stall != COLS) begin
      failures++;
      $display("FAIL wrap_scroll_low got=%0d required=%0d", low, COLS);
    end
    for (int k = 0; k < 4; k++) begin
      int c = (k < 2) ? COLS - 1 : int'($urandom_range(0, COLS - 1));
      int r = (k % 2 == 0) ? 28 : 29;
      read_cell(c, r, oc, oa);
      exp_cell(c, r, ec, ea);
      checks++;
      if (oc !== ec || oa !== ea) begin
        failures++;
        $display("FAIL wrap_cell(%0d,%0d) got=%h/%h required=%h/%h", c, r, oc, oa, ec, ea);
      end
    end
  endtask

  task automatic test_bs_ff();
    int low, stall, r;
    logic [7:0] oc, oa, ec, ea;
    send_byte(8'h0D, 8'h00, low, stall);
    send_byte(8'h08, 8'h00, low, stall);
    r = mrow;
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'(r)) begin
      failures++;
      $display("FAIL bs_at_zero got=(%0d,%0d) required=(0,%0d)", cursor_col, cursor_row, r);
    end
    send_byte(8'h51, 8'h5C, low, stall);
    send_byte(8'h08, 8'h00, low, stall);
    send_byte(8'h08, 8'h00, low, stall);
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'(r)) begin
      failures++;
      $display("FAIL bs_cursor got=(%0d,%0d) required=(0,%0d)", cursor_col, cursor_row, r);
    end
    read_cell(0, r, oc, oa);
    exp_cell(0, r, ec, ea);
    checks++;
    if (oc !== ec || oa !== ea) begin
      failures++;
      $display("FAIL bs_no_erase got=%h/%h required=%h/%h", oc, oa, ec, ea);
    end
    send_byte(8'h0C, 8'h00, low, stall);
    checks++;
    if (low != COLS * ROWS || stall != COLS * ROWS) begin
      failures++;
      $display("FAIL ff_low got=%0d required=%0d", low, COLS * ROWS);
    end
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      failures++;
      $display("FAIL ff_cursor got=(%0d,%0d) required=(0,0)", cursor_col, cursor_row);
    end
    for (int i = 0; i < 20; i++) begin
      int c = (i == 0) ? 0 : int'($urandom_range(0, COLS - 1));
      int rr = (i == 0) ? 0 : int'($urandom_range(0, ROWS - 1));
      read_cell(c, rr, oc, oa);
      exp_cell(c, rr, ec, ea);
      checks++;
      if (oc !== ec || oa !== ea) begin
        failures++;
        $display("FAIL ff_cell(%0d,%0d) got=%h/%h required=%h/%h", c, rr, oc, oa, ec, ea);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int low, stall, n;
    logic [7:0] oc, oa, ec, ea;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(8'h41, 8'h5A)), 8'h1F, low, stall);
    cx = 12'd9; cy = 11'd0;
    char_valid = 1'b1; char_data = 8'h0C; char_attr = 8'h00;
    @(posedge clk_pixel);
    #1;
    char_valid = 1'b0;
    void'(m_byte(8'h0C, 8'h00));
    repeat (100) @(posedge clk_pixel);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (char_ready !== 1'b0 || codepoint !== 8'h20 || attribute !== 8'h00 ||
        cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      failures++;
      $display("FAIL midclear_reset got ready=%b cp=%h at=%h cur=(%0d,%0d) required 0/20/00/(0,0)",
               char_ready, codepoint, attribute, cursor_col, cursor_row);
    end
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    m_blank_all(); mcol = 0; mrow = 0;
    wait_ready(n);
    checks++;
    if (n != COLS * ROWS) begin
      failures++;
      $display("FAIL midclear_restart_len got=%0d required=%0d", n, COLS * ROWS);
    end
    for (int i = 0; i < 20; i++) begin
      int c = (i < 2) ? i : int'($urandom_range(0, COLS - 1));
      int r = (i < 2) ? 0 : int'($urandom_range(0, ROWS - 1));
      read_cell(c, r, oc, oa);
      exp_cell(c, r, ec, ea);
      checks++;
      if (oc !== ec || oa !== ea) begin
        failures++;
        $display("FAIL midclear_cell(%0d,%0d) got=%h/%h required=%h/%h", c, r, oc, oa, ec, ea);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ab();
    test_row_fill();
    test_back_to_back();
    test_random_stream();
    test_scroll();
    test_bs_ff();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
